// File: rtl/stl_uart_pkg.sv
// Shared definitions for the UART TX byte path: arbiter state encoding,
// byte width, default mid-packet timeout and a small index helper.
package stl_uart_pkg;

  localparam int BYTE_W          = 8;
  localparam int TIMEOUT_DEFAULT = 1_000_000;

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  // Index 'step' positions after 'base' in a ring of 'n' entries.
  function automatic int ring_index(input int base, input int step, input int n);
    return (base + step) % n;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin select: first asserted request found scanning
// upward from last_grant+1 with wrap. Shared by TX arbitration and RX demux.
module rr_pick
  import stl_uart_pkg::*;
#(
  parameter int N = 2,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last_grant,
  output logic [W-1:0] pick,
  output logic         any_valid
);

  // Scan from the farthest position back to the nearest so the nearest
  // requester after last_grant is the final (winning) assignment.
  always_comb begin
    pick      = last_grant;
    any_valid = |req;
    for (int k = N; k >= 1; k--) begin
      for (int i = 0; i < N; i++) begin
        if (req[i] && (ring_index(int'(last_grant), k, N) == i)) begin
          pick = W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter feeding one UART TX byte path through a
// one-byte output buffer. Optional mid-packet timeout: UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import stl_uart_pkg::*;
#(
  parameter int NUM_SRC        = 2,
  parameter int GRANT_W        = 3,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [BYTE_W*NUM_SRC-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_last,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic [BYTE_W-1:0]         tx_data,
  output logic [GRANT_W-1:0]        debug_grant,
  output logic                      debug_state,
  output logic                      timeout_flag
);

  arb_state_t          state_reg;
  logic [GRANT_W-1:0]  grant_reg;
  logic                obuf_valid_reg;
  logic [BYTE_W-1:0]   obuf_data_reg;

  logic [GRANT_W-1:0]  pick;
  logic                any_valid;
  logic                sel_valid;
  logic                sel_last;
  logic [BYTE_W-1:0]   sel_data;
  logic                can_load;
  logic                accept;
  logic                timeout_hit;

  // grant_reg doubles as last_grant while in ARB: the release paths always
  // leave it holding the source that was just served.
  rr_pick #(
    .N (NUM_SRC),
    .W (GRANT_W)
  ) u_rr_pick (
    .req        (src_valid),
    .last_grant (grant_reg),
    .pick       (pick),
    .any_valid  (any_valid)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_reg == GRANT_W'(i)) begin
        sel_valid = src_valid[i];
        sel_last  = src_last[i];
        sel_data  = src_data[BYTE_W*i +: BYTE_W];
      end
    end
  end

  assign can_load = (state_reg == ST_LOCKED) && (!obuf_valid_reg || tx_ready);
  assign accept   = can_load && sel_valid;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_ready
    assign src_ready[gi] = can_load && (grant_reg == GRANT_W'(gi));
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TO_W-1:0] idle_cnt_reg;
  logic            timeout_flag_reg;

  // Any locked cycle without an accepted byte counts, including backpressure.
  assign timeout_hit = (state_reg == ST_LOCKED) && !accept &&
                       (idle_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt_reg     <= '0;
      timeout_flag_reg <= 1'b0;
    end else begin
      timeout_flag_reg <= timeout_hit;
      if ((state_reg != ST_LOCKED) || accept || timeout_hit) begin
        idle_cnt_reg <= '0;
      end else begin
        idle_cnt_reg <= idle_cnt_reg + 1'b1;
      end
    end
  end

  assign timeout_flag = timeout_flag_reg;
`else
  assign timeout_hit  = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_ARB;
      grant_reg      <= GRANT_W'(NUM_SRC - 1);
      obuf_valid_reg <= 1'b0;
      obuf_data_reg  <= '0;
    end else begin
      case (state_reg)
        ST_ARB: begin
          if (any_valid) begin
            grant_reg <= pick;
            state_reg <= ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if ((accept && sel_last) || timeout_hit) begin
            state_reg <= ST_ARB;
          end
        end
        default: state_reg <= ST_ARB;
      endcase

      // Load and drain in the same cycle keeps the buffer full: 1 byte/cycle.
      if (accept) begin
        obuf_valid_reg <= 1'b1;
        obuf_data_reg  <= sel_data;
      end else if (tx_ready) begin
        obuf_valid_reg <= 1'b0;
      end
    end
  end

  assign tx_valid    = obuf_valid_reg;
  assign tx_data     = obuf_data_reg;
  assign debug_grant = grant_reg;
  assign debug_state = logic'(state_reg);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: per-source packet stores, a packet-level
// round-robin reference that predicts the TX byte stream, and directed cases.
module tb_uart_tx_arbiter;

  localparam int N  = 3;
  localparam int GW = 3;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    src_valid = '0;
  logic [N-1:0]    src_ready;
  logic [8*N-1:0]  src_data = '0;
  logic [N-1:0]    src_last = '0;
  logic            tx_valid;
  logic            tx_ready = 1'b0;
  logic [7:0]      tx_data;
  logic [GW-1:0]   debug_grant;
  logic            debug_state;
  logic            timeout_flag;

  uart_tx_arbiter #(
    .NUM_SRC        (N),
    .GRANT_W        (GW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .src_valid    (src_valid),
    .src_ready    (src_ready),
    .src_data     (src_data),
    .src_last     (src_last),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_data      (tx_data),
    .debug_grant  (debug_grant),
    .debug_state  (debug_state),
    .timeout_flag (timeout_flag)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Source stores: entry = {first, last, data}.
  logic [9:0] smem [N][1024];
  int swr[N], srd[N];
  int plen[N][64];
  int pcnt[N], pnext[N], plan_ptr[N];

  logic [7:0] exp_q[$];
  int         pkt_q[$];
  logic [7:0] tx_log[$];
  int         model_last = N - 1;

  logic [N-1:0] acc = '0;
  logic [N-1:0] prev_bub = '0;
  int acc_cnt[N], last_acc_cyc[N];
  int cyc = 0, stall = 0, mode = 0, to_cnt = 0, to_cyc = 0;
  int first_tx_cyc = -1, first_fire_cyc = -1, last_fire_cyc = -1;
  bit mon_en = 1'b0, bub_en = 1'b0;

  task automatic add_packet(input int s, input int len, input bit seq, input logic [7:0] base);
    logic [7:0] d;
    for (int b = 0; b < len; b++) begin
      d = seq ? 8'(base + 8'(b)) : 8'($urandom);
      smem[s][swr[s]] = {(b == 0), (b == len - 1), d};
      swr[s]++;
    end
    plen[s][pcnt[s]] = len;
    pcnt[s]++;
  endtask

  // Packet-level reference: the next packet always comes from the first
  // source after the previous winner that still has a packet waiting.
  task automatic plan();
    int  c, chosen;
    bit  found;
    forever begin
      found = 1'b0;
      chosen = 0;
      for (int k = 1; k <= N; k++) begin
        c = (model_last + k) % N;
        if (!found && pnext[c] < pcnt[c]) begin
          found = 1'b1;
          chosen = c;
        end
      end
      if (!found) break;
      pkt_q.push_back(chosen);
      for (int b = 0; b < plen[chosen][pnext[chosen]]; b++) begin
        exp_q.push_back(smem[chosen][plan_ptr[chosen]][7:0]);
        plan_ptr[chosen]++;
      end
      pnext[chosen]++;
      model_last = chosen;
    end
  endtask

  task automatic monitor();
    logic [N-1:0] allowed;
    int g;
    acc = src_valid & src_ready;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        acc_cnt[i]++;
        last_acc_cyc[i] = cyc;
      end
    end
    if (tx_valid && tx_ready) tx_log.push_back(tx_data);
    if (timeout_flag) begin
      to_cnt++;
      to_cyc = cyc;
    end
    if (!mon_en) begin
      stall = 0;
      return;
    end
    allowed = '0;
    if (pkt_q.size() > 0) allowed[pkt_q[0]] = 1'b1;
    check_eq("ready_mask", 32'(src_ready & ~allowed), 0);
    if (tx_valid && !tx_ready) check_eq("bp_ready", 32'(src_ready), 0);
    if (tx_valid) begin
      if (first_tx_cyc < 0) first_tx_cyc = cyc;
      check_eq("tx_data", 32'(tx_data), (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'h1ff);
      if (tx_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        if (first_fire_cyc < 0) first_fire_cyc = cyc;
        last_fire_cyc = cyc;
      end
    end
    if (|acc) begin
      stall = 0;
      g = (pkt_q.size() > 0) ? pkt_q[0] : 0;
      check_eq("acc_src", 32'(acc), 32'(1 << g));
      check_eq("acc_grant", 32'(debug_grant), 32'(g));
      check_eq("acc_state", 32'(debug_state), 1);
      if (acc[g] && src_last[g] && pkt_q.size() > 0) void'(pkt_q.pop_front());
    end else if (pkt_q.size() > 0) begin
      stall++;
    end
  endtask

  task automatic drive();
    logic [9:0] e;
    bit force_go, bub;
    force_go = (stall >= 4);
    for (int i = 0; i < N; i++) if (acc[i]) srd[i]++;
    acc = '0;
    case (mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ~tx_ready;
      default: tx_ready = force_go ? 1'b1 : ($urandom_range(0, 2) != 0);
    endcase
    for (int i = 0; i < N; i++) begin
      if (srd[i] < swr[i]) begin
        e = smem[i][srd[i]];
        bub = bub_en && !e[9] && !force_go && !prev_bub[i] && ($urandom_range(0, 3) == 0);
        prev_bub[i] = bub;
        src_valid[i] = !bub;
        src_last[i]  = bub ? 1'($urandom) : e[8];
        src_data[8*i +: 8] = e[7:0];
      end else begin
        prev_bub[i] = 1'b0;
        src_valid[i] = 1'b0;
        src_last[i]  = 1'($urandom);
        src_data[8*i +: 8] = 8'h00;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
    drive();
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || pkt_q.size() > 0) && n < limit) begin
      step();
      n++;
    end
    check_eq("drain_in_time", 32'(exp_q.size() + pkt_q.size()), 0);
    repeat (3) step();
  endtask

  // Only used while no source is being served, so skipping drive() is safe.
  task automatic peek_idle(input string tag, input int g, input bit st);
    @(negedge clk);
    check_eq({tag, "_grant"}, 32'(debug_grant), 32'(g));
    check_eq({tag, "_state"}, 32'(debug_state), 32'(st));
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic flush_all();
    for (int i = 0; i < N; i++) begin
      srd[i] = swr[i];
      plan_ptr[i] = swr[i];
      pnext[i] = pcnt[i];
    end
    exp_q.delete();
    pkt_q.delete();
    src_valid = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] mask;
    int a0, a1, np;
    for (int i = 0; i < N; i++) begin
      swr[i] = 0; srd[i] = 0; pcnt[i] = 0; pnext[i] = 0; plan_ptr[i] = 0;
      acc_cnt[i] = 0; last_acc_cyc[i] = 0;
    end
    repeat (3) step();

    // Reset state.
    @(negedge clk);
    check_eq("rst_tx_valid", 32'(tx_valid), 0);
    check_eq("rst_tx_data", 32'(tx_data), 0);
    check_eq("rst_src_ready", 32'(src_ready), 0);
    check_eq("rst_grant", 32'(debug_grant), N - 1);
    check_eq("rst_state", 32'(debug_state), 0);
    check_eq("rst_timeout", 32'(timeout_flag), 0);
    @(posedge clk);
    cyc++;
    #1;

    // Contention at reset exit: src0 packet fully before src1 packet.
    add_packet(0, 16, 1'b1, 8'hA0);
    add_packet(1, 16, 1'b1, 8'hB0);
    plan();
    tx_log.delete();
    mode = 0; mon_en = 1'b1;
    step();
    reset = 1'b0;
    wait_drain(200);
    check_eq("cont_len", 32'(tx_log.size()), 32);
    check_eq("cont_first_b", (tx_log.size() > 16) ? 32'(tx_log[16]) : 32'h1ff, 32'hB0);
    check_eq("cont_last_a", (tx_log.size() > 15) ? 32'(tx_log[15]) : 32'h1ff, 32'hAF);

    // Single packet latency and back-to-back throughput.
    first_tx_cyc = -1; first_fire_cyc = -1; last_fire_cyc = -1;
    add_packet(0, 16, 1'b1, 8'h00);
    plan();
    a0 = cyc + 1;
    wait_drain(200);
    check_eq("lat_first_tx", 32'(first_tx_cyc - a0), 2);
    check_eq("lat_burst", 32'(last_fire_cyc - first_fire_cyc), 15);
    peek_idle("single_end", 0, 1'b0);

    // Randomized phases: fairness with 4-byte packets, then random subsets.
    for (int ph = 0; ph < 6; ph++) begin
      mask = (ph < 2) ? '1 : N'($urandom_range(1, (1 << N) - 1));
      mode = (ph == 0) ? 0 : 2;
      bub_en = (ph != 0);
      for (int i = 0; i < N; i++) begin
        if (mask[i]) begin
          np = (ph == 0) ? 2 : int'($urandom_range(1, 3));
          for (int p = 0; p < np; p++)
            add_packet(i, (ph == 0) ? 4 : int'($urandom_range(1, 6)), 1'b0, 8'h00);
        end
      end
      plan();
      wait_drain(800);
      peek_idle("phase_end", model_last, 1'b0);
    end

    // Backpressure: tx_ready toggling every cycle.
    mode = 1; bub_en = 1'b0;
    add_packet(2, 16, 1'b0, 8'h00);
    plan();
    wait_drain(400);

    // Reset in the middle of a src1 packet.
    mon_en = 1'b0; mode = 0;
    add_packet(1, 12, 1'b1, 8'h60);
    a1 = acc_cnt[1];
    for (int n = 0; n < 50 && acc_cnt[1] < a1 + 5; n++) step();
    check_eq("mid_bytes", 32'(acc_cnt[1] - a1), 5);
    reset = 1'b1;
    flush_all();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_eq("midrst_tx_valid", 32'(tx_valid), 0);
    check_eq("midrst_ready", 32'(src_ready), 0);
    check_eq("midrst_grant", 32'(debug_grant), N - 1);
    check_eq("midrst_state", 32'(debug_state), 0);
    @(posedge clk);
    cyc++;
    #1;
    reset = 1'b0;
    model_last = N - 1;
    add_packet(1, 3, 1'b0, 8'h00);
    add_packet(0, 3, 1'b0, 8'h00);
    plan();
    mon_en = 1'b1; mode = 2;
    wait_drain(200);

    // Source stalls mid-packet while another source waits.
    mon_en = 1'b0; mode = 0;
    tx_log.delete();
    to_cnt = 0;
    a0 = acc_cnt[0];
    smem[0][swr[0]] = {2'b10, 8'h51}; swr[0]++;
    smem[0][swr[0]] = {2'b00, 8'h52}; swr[0]++;
    smem[0][swr[0]] = {2'b00, 8'h53}; swr[0]++;
    repeat (6) step();
    check_eq("stall_src0_bytes", 32'(acc_cnt[0] - a0), 3);
    a1 = acc_cnt[1];
    add_packet(1, 4, 1'b1, 8'hC0);
`ifdef UART_TX_ARB_TIMEOUT_EN
    repeat (30) step();
    check_eq("to_pulses", 32'(to_cnt), 1);
    check_eq("to_delay", 32'(to_cyc - last_acc_cyc[0]), 9);
    check_eq("to_src1_bytes", 32'(acc_cnt[1] - a1), 4);
    check_eq("to_log_len", 32'(tx_log.size()), 7);
    check_eq("to_log_order", (tx_log.size() > 3) ? 32'(tx_log[3]) : 32'h1ff, 32'hC0);
`else
    repeat (100) step();
    check_eq("hold_src1_bytes", 32'(acc_cnt[1] - a1), 0);
    check_eq("hold_pulses", 32'(to_cnt), 0);
    check_eq("hold_log_len", 32'(tx_log.size()), 3);
    peek_idle("hold", 0, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART TX byte path (the UART handler's response input) between NUM_SRC byte-stream sources, e.g. the STL client response stream, a debug/status streamer and an ADC dump.
- Arbitration is packet-atomic: once a source is granted, bytes from no other source reach the UART until the granted source marks its last byte.
- Round-robin between packets; a one-byte registered output stage decouples source timing from the UART handler.

Parameters:
NUM_SRC, 2, number of requesting byte streams (legal 2..8)
GRANT_W, 3, grant index width; must satisfy 2**GRANT_W >= NUM_SRC
TIMEOUT_CYCLES, 1_000_000, idle cycles tolerated mid-packet before forced release (10 ms at 100 MHz); used only with the optional feature

Ports:
clk  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high reset
src_valid  in  NUM_SRC  per-source byte valid
src_ready  out  NUM_SRC  per-source byte accept
src_data  in  8*NUM_SRC  per-source byte; source i on bits [8i+7:8i]
src_last  in  NUM_SRC  per-source end-of-packet marker, qualified by src_valid
tx_valid  out  1  byte valid to UART handler
tx_ready  in  1  UART handler accept
tx_data  out  8  byte to UART handler
debug_grant  out  GRANT_W  current/last granted source index
debug_state  out  1  0 = ARB, 1 = LOCKED
timeout_flag  out  1  one-cycle pulse on forced release; constant 0 without the optional feature

Behaviour:
- Reset:
  - state = ARB; last_grant = NUM_SRC-1, so source 0 wins the first arbitration.
  - Output buffer is emptied; any held byte is discarded.
  - Outputs: tx_valid=0, tx_data=0, src_ready=0, debug_grant=NUM_SRC-1, debug_state=0, timeout_flag=0.
- Reset mid-packet: the partial packet is abandoned and the next arbitration starts fresh. The arbiter does not repair framing.
- Byte transfer: occurs on a cycle where valid && ready. src_ready never depends combinationally on src_valid.
- State ARB:
  - src_ready = 0 for all sources.
  - If any src_valid is high, select the first valid source scanning from (last_grant+1) mod NUM_SRC upward with wrap.
  - Register grant = selected source and go to LOCKED. Arbitration costs exactly one cycle.
  - If no source is valid, stay in ARB.
- State LOCKED:
  - src_ready[grant] = (!obuf_valid || tx_ready); all other src_ready = 0.
  - On an accepted byte, load obuf_data and set obuf_valid=1.
  - If the accepted byte has src_last=1: last_grant <= grant, go to ARB.
- Output buffer:
  - tx_valid = obuf_valid; tx_data = obuf_data.
  - A load and a drain in the same cycle keep obuf_valid=1 with the new byte, giving a sustained 1 byte/cycle.
  - A drain without a load clears obuf_valid.
  - tx_data holds its value while tx_valid=1 && !tx_ready.
- Latency: 1 cycle from source acceptance to tx_valid.
- Packet gap: a new grant may be issued while the previous last byte still sits in obuf; the byte order remains correct.
- Packet length is unlimited. A 1-byte packet (src_last on the first byte) is legal.
- A source deasserting src_valid mid-packet keeps the lock; other sources stay blocked (see optional feature).
- src_last while src_valid=0 is ignored.

Optional Feature:
UART_TX_ARB_TIMEOUT_EN
- Defined:
  - A counter in LOCKED increments on every cycle with no accepted byte and clears on each accepted byte.
  - When the counter reaches TIMEOUT_CYCLES-1 with no accept: pulse timeout_flag for 1 cycle, set last_grant <= grant, go to ARB.
  - The counter resets on entry to LOCKED.
  - Backpressure (tx_ready=0 with obuf full) also counts toward the timeout.
- Undefined: no counter is instantiated, timeout_flag is tied to 0, and the lock is held indefinitely.

Decomposition:
- Shared package (stl_uart_pkg): ARB/LOCKED state encoding constants, the default timeout constant, and a byte-width localparam.
- One natural sub-module, rr_pick: combinational round-robin priority select (inputs: request vector and last_grant; outputs: index and any_valid). It is reusable by future UART RX demux logic.
- Output buffer and FSM stay in the top module.

Test Plan:
- Single packet: src0 sends 16 bytes 0x00..0x0F with src_last on 0x0F, tx_ready=1 -> tx emits 0x00..0x0F back-to-back; first tx_valid 2 cycles after src_valid (1 arbitration + 1 buffer); state returns to ARB.
- Contention: src0 and src1 both raise valid at reset exit with 16-byte packets (src0 bytes 0xA0.., src1 bytes 0xB0..) -> all 16 0xA0.. bytes, then all 16 0xB0..; no interleave; src_ready[1]=0 throughout src0's packet.
- Round-robin fairness with NUM_SRC=3: all sources continuously request 4-byte packets -> grant sequence 0,1,2,0,1,2; debug_grant matches.
- Backpressure: tx_ready toggles 1/0 every cycle during a 16-byte packet -> no byte lost or duplicated; tx_data stable while tx_valid && !tx_ready; src_ready low whenever obuf is full and tx_ready=0.
- Reset mid-packet: assert reset after byte 5 of src1's packet -> next cycle tx_valid=0, all src_ready=0, debug_grant=NUM_SRC-1; the next request from src0 is granted first.
- Timeout (macro defined, TIMEOUT_CYCLES=8): src0 sends 3 bytes then drops valid -> timeout_flag pulses once after 8 idle cycles; a pending src1 packet is granted on the following arbitration. Without the macro, the lock is held and src1 is never granted in 100 cycles.
